input_event_capture: RTL

//  Multi-channel input change recorder. Samples CHANNELS packed input words (joystick, analog, paddle,

---
 rtl/input_event_pkg.sv | 38 +++
 rtl/input_event_fifo.sv | 66 ++++++
 rtl/input_event_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/input_event_pkg.sv
// ---------------------------------------------------------------------------
// input_event_pkg
// Shared types and helpers for the input event capture block.
//   cap_state_t    : capture FSM states (IDLE waits for a sample, SCAN walks channels)
//   chanIdxWidth() : width of a channel index (never below 1 bit)
//   eventWidth()   : width of one packed event {channel, data, ts}
//   packEvent()    : builds a packed event from its fields
// ---------------------------------------------------------------------------
package input_event_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cap_state_t;

    localparam int MAX_EVENT_WIDTH = 256;

    function automatic int chanIdxWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int eventWidth(input int channels, input int width, input int tsWidth);
        return chanIdxWidth(channels) + width + tsWidth;
    endfunction

    // Fields are right-aligned in wide containers so one function serves every
    // parameterisation; the caller truncates to eventWidth().
    function automatic logic [MAX_EVENT_WIDTH-1:0] packEvent(
        input logic [MAX_EVENT_WIDTH-1:0] channel,
        input logic [MAX_EVENT_WIDTH-1:0] data,
        input logic [MAX_EVENT_WIDTH-1:0] ts,
        input int width,
        input int tsWidth
    );
        return (channel << (width + tsWidth)) | (data << tsWidth) | ts;
    endfunction

endpackage

// File: rtl/input_event_fifo.sv
// ---------------------------------------------------------------------------
// input_event_fifo
// Single-clock show-ahead FIFO holding packed events.
//   clk, reset : clock and synchronous active-high reset
//   push, wdata: write request and data (dropped when no room)
//   pop        : pop the head entry (ignored when empty)
//   rdata      : head entry, valid whenever empty is low
//   count      : number of entries held
//   full/empty : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module input_event_fifo #(
    parameter int DEPTH = 16,
    parameter int EW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [EW-1:0]          wdata,
    input  logic                   pop,
    output logic [EW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPop;
    logic          doPush;

    // Handshake qualification: pops need data, pushes need room (or a
    // simultaneous pop freeing a slot).
    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == (AW+1)'(DEPTH));
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
        rdata  = mem_q[rdPtr_q];
        count  = count_q;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            if (doPush && !doPop)      count_q <= count_q + 1'b1;
            else if (doPop && !doPush) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata;
    end

endmodule

// File: rtl/input_event_capture.sv
// ---------------------------------------------------------------------------
// input_event_capture
// Multi-channel input change recorder. On each sample strobe the packed
// channel words are snapshotted and scanned one channel per cycle; every
// channel that differs from its last reported value is queued as a
// timestamped event {channel, data, ts} in a show-ahead FIFO.
//   clk_sys, reset       : clock, synchronous active-high reset
//   ce_sample            : one-cycle sample strobe (also advances the timestamp)
//   in_data              : CHANNELS packed words, channel k at [k*WIDTH +: WIDTH]
//   rd_en                : pop the head event
//   evt_valid/_channel/_data/_ts : head event (all zero while empty)
//   evt_count            : events queued
//   overflow/clr_overflow: sticky drop flag and its clear (set wins)
// Optional build macro INPUT_EVENT_DEBOUNCE_EN: each channel only presents a
// new value once the raw sample has been identical for DB_SAMPLES strobes.
// ---------------------------------------------------------------------------
module input_event_capture
    import input_event_pkg::*;
#(
    parameter int CHANNELS   = 6,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 24,
    parameter int DB_SAMPLES = 3
) (
    input  logic                                clk_sys,
    input  logic                                reset,
    input  logic                                ce_sample,
    input  logic [CHANNELS*WIDTH-1:0]           in_data,
    input  logic                                rd_en,
    output logic                                evt_valid,
    output logic [chanIdxWidth(CHANNELS)-1:0]   evt_channel,
    output logic [WIDTH-1:0]                    evt_data,
    output logic [TS_WIDTH-1:0]                 evt_ts,
    output logic [$clog2(DEPTH):0]              evt_count,
    output logic                                overflow,
    input  logic                                clr_overflow
);

    localparam int CW = chanIdxWidth(CHANNELS);
    localparam int EW = eventWidth(CHANNELS, WIDTH, TS_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

    if (CHANNELS < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DB_SAMPLES < 1) begin : gParamCheck
        $error("input_event_capture: illegal parameterisation");
    end

    cap_state_t          state_q;
    logic [CW-1:0]       idx_q;
    logic [WIDTH-1:0]    snap_q [CHANNELS];
    logic [WIDTH-1:0]    last_q [CHANNELS];
    logic [TS_WIDTH-1:0] snapTs_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic                primed_q;
    logic                pending_q;
    logic                overflow_q;

    logic [WIDTH-1:0]    snapSrc [CHANNELS];
    logic [WIDTH-1:0]    curSnap;
    logic                differ;
    logic                pushReq;
    logic                fifoAccept;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [EW-1:0]       pushData;
    logic [EW-1:0]       headData;

`ifdef INPUT_EVENT_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_SAMPLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_SAMPLES);

    logic [WIDTH-1:0] prev_q  [CHANNELS];
    logic [DBW-1:0]   cnt_q   [CHANNELS];
    logic [WIDTH-1:0] cand_q  [CHANNELS];
    logic [DBW-1:0]   cnt_d   [CHANNELS];
    logic [WIDTH-1:0] cand_d  [CHANNELS];

    // Stability counter per channel: restarts at 1 on any raw change and
    // saturates at DB_SAMPLES. The candidate is forwarded in the same cycle it
    // qualifies so the snapshot sees it without an extra strobe of latency.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k]  = cnt_q[k];
            cand_d[k] = cand_q[k];
            if (ce_sample) begin
                if (in_data[k*WIDTH +: WIDTH] != prev_q[k]) cnt_d[k] = DBW'(1);
                else if (cnt_q[k] != DB_MAX)               cnt_d[k] = cnt_q[k] + 1'b1;
                if (cnt_d[k] == DB_MAX) cand_d[k] = in_data[k*WIDTH +: WIDTH];
            end
            snapSrc[k] = cand_d[k];
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                prev_q[k] <= '0;
                cnt_q[k]  <= '0;
                cand_q[k] <= '0;
            end
        end else if (ce_sample) begin
            for (int k = 0; k < CHANNELS; k++) begin
                prev_q[k] <= in_data[k*WIDTH +: WIDTH];
                cnt_q[k]  <= cnt_d[k];
                cand_q[k] <= cand_d[k];
            end
        end
    end
`else
    // Without debounce the raw inputs feed the snapshot directly.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            snapSrc[k] = in_data[k*WIDTH +: WIDTH];
        end
    end
`endif

    // Scan datapath: compare the current channel against its last reported
    // value. The priming scan after reset only loads last_q.
    always_comb begin
        curSnap    = snap_q[idx_q];
        differ     = (curSnap != last_q[idx_q]);
        pushReq    = (state_q == SCAN) && primed_q && differ;
        fifoAccept = !fifoFull || (rd_en && !fifoEmpty);
        pushData   = EW'(packEvent(MAX_EVENT_WIDTH'(idx_q), MAX_EVENT_WIDTH'(curSnap),
                                   MAX_EVENT_WIDTH'(snapTs_q), WIDTH, TS_WIDTH));
    end

    // Capture FSM, timestamp counter and sticky overflow. A strobe that lands
    // mid-scan is remembered in pending_q and starts the next scan right after
    // the current one; further strobes while pending are merged.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snapTs_q   <= '0;
            ts_q       <= '0;
            primed_q   <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= '0;
                last_q[k] <= '0;
            end
        end else begin
            if (ce_sample) ts_q <= ts_q + 1'b1;

            if (pushReq && !fifoAccept) overflow_q <= 1'b1;
            else if (clr_overflow)      overflow_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ce_sample || pending_q) begin
                        for (int k = 0; k < CHANNELS; k++) snap_q[k] <= snapSrc[k];
                        snapTs_q  <= ts_q;
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (ce_sample) pending_q <= 1'b1;
                    // A dropped change keeps the old last_q so it is seen again.
                    if (!primed_q || (differ && fifoAccept)) last_q[idx_q] <= curSnap;
                    if (idx_q == LAST_IDX) begin
                        primed_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    input_event_fifo #(
        .DEPTH(DEPTH),
        .EW   (EW)
    ) uFifo (
        .clk  (clk_sys),
        .reset(reset),
        .push (pushReq),
        .wdata(pushData),
        .pop  (rd_en),
        .rdata(headData),
        .count(evt_count),
        .full (fifoFull),
        .empty(fifoEmpty)
    );

    // Head event fields are forced to zero while the FIFO is empty.
    always_comb begin
        evt_valid   = !fifoEmpty;
        evt_channel = evt_valid ? headData[EW-1 -: CW] : '0;
        evt_data    = evt_valid ? headData[TS_WIDTH +: WIDTH] : '0;
        evt_ts      = evt_valid ? headData[TS_WIDTH-1:0] : '0;
        overflow    = overflow_q;
    end

endmodule
